tradeoff_rr_scheduler: RTL and testbench
========================================

Name: tradeoff_rr_scheduler

Overview:
- Shares one Tradeoff_16bits search core among NUM_REQ requesters using round-robin arbitration.
- Accepts W operands over per-requester valid/ready channels and sequences the core: load W, start, wait for found (or timeout).
- Returns N, tagged with the requester ID, over a single shared valid/ready response channel.
- Sits between the request sources and the core; the core itself is unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_BITS, 2, width of requester ID; must equal clog2(NUM_REQ).
- W_BITS, 30, operand width.
- N_BITS, 17, result width.
- TIMEOUT_CYC, 200000, maximum cycles to wait for core_found before aborting.
- CNT_BITS, 18, timeout counter width; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_w  in  NUM_REQ*W_BITS  operands, packed; requester i uses bits [i*W_BITS +: W_BITS].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_BITS  requester ID that owns the result.
- rsp_n  out  N_BITS  result N; 0 on timeout.
- rsp_timeout  out  1  result aborted by timeout.
- core_w  out  W_BITS  operand driven to the core; held stable from START through end of WAIT.
- core_start  out  1  one-cycle pulse that restarts the core search.
- core_found  in  1  core done; level signal.
- core_n  in  N_BITS  core result; valid while core_found=1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE; rr pointer=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_n=0, rsp_timeout=0.
  - core_w=0, core_start=0, busy=0; timeout counter=0.
- Reset asserted mid-operation: abort immediately; the in-flight request is lost and no response is issued.
- IDLE:
  - If any req_valid=1, grant one requester by round-robin: search starts at rr pointer and takes the first valid index (wrap modulo NUM_REQ).
  - Assert req_ready for the granted index only, combinationally in this same cycle.
  - On that edge: latch req_w slice into core_w and the index into an internal ID; set rr pointer = granted+1 (wraps); go to START.
- START: core_start=1 for exactly one cycle; counter cleared; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - core_found=1 sampled: capture core_n into rsp_n, rsp_timeout=0, go to RESP.
  - Otherwise, counter reaching TIMEOUT_CYC-1: rsp_n=0, rsp_timeout=1, go to RESP.
  - If core_found and the timeout hit in the same cycle, found wins.
  - core_found is ignored in every state other than WAIT. This includes the START cycle, so a stale found from the previous job is masked.
- RESP:
  - rsp_valid=1; rsp_id, rsp_n and rsp_timeout are held stable until the rsp_valid & rsp_ready handshake.
  - On handshake: rsp_valid=0 next cycle; go to IDLE.
  - Once rsp_valid is raised it never drops without the handshake.
- Throughput and latency:
  - One job in flight; req_ready is 0 in every state except IDLE.
  - Minimum latency, request accept to rsp_valid: 3 cycles when core_found=1 on the first WAIT cycle.
  - Back-to-back: a new grant can occur in the cycle after the response handshake (IDLE lasts ≥1 cycle).
- Fairness: a requester holding req_valid continuously is granted within NUM_REQ jobs.
- Requester rules: a requester must hold req_valid and req_w stable until it sees req_ready; the scheduler does not check this.

Test Plan:
- Single requester: req 0 sends W=1073741823; core model raises found after 10 cycles with N=65535 → exactly one core_start pulse; rsp_valid with rsp_id=0, rsp_n=65535, rsp_timeout=0; latency 12 cycles.
- Fairness: all 4 requesters valid continuously, W=i+100 → grant order 0,1,2,3,0,…; core_w matches the granted slice each job; no requester starved across 12 jobs.
- Timeout: TIMEOUT_CYC=50, core never asserts found → rsp_timeout=1, rsp_n=0 exactly 50 cycles after START; next request is then served normally.
- Backpressure: rsp_ready=0 for 20 cycles after rsp_valid → rsp_id/rsp_n stable throughout; req_ready stays 0; no second core_start.
- Stale found: core_found already high when the next job starts → masked during START; result is taken only from a found seen in WAIT.
- Reset mid-WAIT: drop rst_n for 3 cycles during WAIT → all outputs at reset values immediately; rr pointer=0; no response for the aborted job; the next request is granted starting from index 0.

Source files
------------

// File: rtl/tradeoff_rr_scheduler.sv
// Round-robin front end sharing one Tradeoff_16bits search core among NUM_REQ requesters.
// One job in flight: grant, load W, pulse start, wait for found or timeout, return tagged N.
//
// state | meaning
// IDLE  | no job; round-robin grant offered to valid requesters
// START | operand latched on core_w; one-cycle core_start pulse
// WAIT  | counting cycles until core_found or timeout
// RESP  | result held on the response channel until handshake
module tradeoff_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ID_BITS     = 2,
  parameter int W_BITS      = 30,
  parameter int N_BITS      = 17,
  parameter int TIMEOUT_CYC = 200000,
  parameter int CNT_BITS    = 18
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*W_BITS-1:0]   req_w,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_BITS-1:0]          rsp_id,
  output logic [N_BITS-1:0]           rsp_n,
  output logic                        rsp_timeout,
  output logic [W_BITS-1:0]           core_w,
  output logic                        core_start,
  input  logic                        core_found,
  input  logic [N_BITS-1:0]           core_n,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic [ID_BITS-1:0]  rr_ptr;
  logic [ID_BITS-1:0]  rr_nxt;
  logic [ID_BITS-1:0]  grant_idx;
  logic [ID_BITS-1:0]  scan_idx;
  logic                grant_any;
  logic [ID_BITS-1:0]  job_id;
  logic [CNT_BITS-1:0] cnt;
  logic                timeout_hit;

  // Scan downward from the farthest offset so the nearest valid index to rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    scan_idx  = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = ID_BITS'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign rr_nxt      = (grant_idx == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign timeout_hit = (cnt == CNT_BITS'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    core_start = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant_any && rst_n) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt            = START;
        end
      end
      START: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_found || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      job_id      <= '0;
      core_w      <= '0;
      cnt         <= '0;
      rsp_n       <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            core_w <= req_w[int'(grant_idx)*W_BITS +: W_BITS];
            job_id <= grant_idx;
            rr_ptr <= rr_nxt;
          end
        end
        START: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          // found takes priority over a coincident timeout
          if (core_found) begin
            rsp_n       <= core_n;
            rsp_timeout <= 1'b0;
          end else if (timeout_hit) begin
            rsp_n       <= '0;
            rsp_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_id = job_id;

endmodule

// File: tb/tb_tradeoff_rr_scheduler.sv
// Randomised bench for tradeoff_rr_scheduler with a behavioural core model and a
// job-level reference model (round-robin pick, expected result and latency).
module tb_tradeoff_rr_scheduler;
  localparam int NR = 4;
  localparam int IB = 2;
  localparam int WB = 30;
  localparam int NB = 17;
  localparam int TO = 50;
  localparam int CB = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*WB-1:0]  req_w;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IB-1:0]     rsp_id;
  logic [NB-1:0]     rsp_n;
  logic              rsp_timeout;
  logic [WB-1:0]     core_w;
  logic              core_start;
  logic              core_found;
  logic [NB-1:0]     core_n;
  logic              busy;

  always #5 clk = ~clk;

  tradeoff_rr_scheduler #(
    .NUM_REQ(NR), .ID_BITS(IB), .W_BITS(WB), .N_BITS(NB),
    .TIMEOUT_CYC(TO), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_w(req_w),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_n(rsp_n), .rsp_timeout(rsp_timeout),
    .core_w(core_w), .core_start(core_start), .core_found(core_found),
    .core_n(core_n), .busy(busy)
  );

  // Core model: found rises dly cycles after the start pulse and stays high
  // (stale) until the next start; core_n switches to the new result on start.
  int          since = 0;
  int          dly_cur = 1;
  int          dly_next = 1;
  logic [NB-1:0] n_cur = '0;
  logic [NB-1:0] n_next = '0;
  always @(posedge clk) begin
    if (core_start) begin
      since   <= 1;
      n_cur   <= n_next;
      dly_cur <= dly_next;
    end else if (since != 0 && since < 100000) begin
      since <= since + 1;
    end
  end
  assign core_found = (since != 0) && (since >= dly_cur);
  assign core_n     = n_cur;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_bad = 0;
  bit          pending [NR];
  logic [WB-1:0] wv [NR];
  int          rr_m = 0;
  int          grants [NR];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = pending[i];
      req_w[i*WB +: WB]    = wv[i];
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < NR; k++) begin
      if (pending[(rr_m + k) % NR]) return (rr_m + k) % NR;
    end
    return -1;
  endfunction

  task automatic arm(input int i, input logic [WB-1:0] w);
    pending[i] = 1'b1;
    wv[i]      = w;
    drive_reqs();
  endtask

  task automatic arm_random();
    for (int i = 0; i < NR; i++) begin
      if (!pending[i] && $urandom_range(1, 0) == 1) begin
        pending[i] = 1'b1;
        wv[i]      = WB'($urandom);
      end
    end
    if (pick() < 0) begin
      int j;
      j = $urandom_range(NR - 1, 0);
      pending[j] = 1'b1;
      wv[j]      = WB'($urandom);
    end
    drive_reqs();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_n"}, rsp_n, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_core_w"}, core_w, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // One complete job; the expected grant, result and latency come from the job-level model.
  task automatic do_job(input int dly, input logic [NB-1:0] n, input int hold);
    int          g, t0, starts, exp_lat;
    bit          got, exp_to;
    logic [WB-1:0] ew;
    logic [NB-1:0] exp_n;
    g = pick();
    if (g < 0) return;
    ew       = wv[g];
    n_next   = n;
    dly_next = dly;
    exp_to   = (dly > TO);
    exp_n    = exp_to ? '0 : n;
    exp_lat  = 2 + (exp_to ? TO : dly);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready != 0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("grant_seen", got, 1);
    if (!got) return;
    chk("req_ready_onehot", req_ready, 64'(1) << g);
    t0 = cyc;
    @(posedge clk);
    #1;
    pending[g] = 1'b0;
    drive_reqs();
    rr_m = (g + 1) % NR;
    grants[g]++;
    starts = 0;
    got    = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
      if (core_start) begin
        starts++;
        chk("core_w", core_w, ew);
      end
      if (req_ready != 0 || !busy) chk("busy_noready", {busy, req_ready}, {1'b1, 4'b0});
    end
    chk("rsp_seen", got, 1);
    if (!got) return;
    chk("latency", cyc - t0, exp_lat);
    chk("start_pulses", starts, 1);
    chk("rsp_id", rsp_id, g);
    chk("rsp_n", rsp_n, exp_n);
    chk("rsp_timeout", rsp_timeout, exp_to);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_id != IB'(g) || rsp_n != exp_n || core_start || req_ready != 0)
        chk("bp_hold", {rsp_valid, rsp_id, rsp_n, core_start, req_ready},
            {1'b1, IB'(g), exp_n, 1'b0, 4'b0});
    end
    if (hold > 0) chk("bp_end_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_drop", {rsp_valid, busy}, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && pick() >= 0; k++) do_job($urandom_range(20, 1), NB'($urandom), 0);
  endtask

  task automatic reset_mid_wait();
    bit got;
    arm(1, WB'($urandom));
    dly_next = 1000;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready != 0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    pending[1] = 1'b0;
    drive_reqs();
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (core_start) begin got = 1'b1; break; end
    end
    chk("rst_start_seen", got, 1);
    repeat (5) @(negedge clk);
    chk("rst_in_wait", {busy, rsp_valid}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_hold_valid", {rsp_valid, busy}, 0);
    end
    rst_n = 1'b1;
    rr_m  = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_no_rsp", {rsp_valid, busy}, 0);
    end
    pending[1] = 1'b1;
    pending[3] = 1'b1;
    wv[1] = WB'($urandom);
    wv[3] = WB'($urandom);
    drive_reqs();
    do_job(7, NB'($urandom), 0);
    drain();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      pending[i] = 1'b0;
      wv[i]      = '0;
      grants[i]  = 0;
    end
    rst_n     = 1'b1;
    req_valid = '0;
    req_w     = '0;
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    arm(0, 30'h3FFF_FFFF);
    do_job(10, 17'd65535, 0);

    for (int i = 0; i < NR; i++) grants[i] = 0;
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < NR; i++) if (!pending[i]) begin pending[i] = 1'b1; wv[i] = WB'(i + 100); end
      drive_reqs();
      do_job($urandom_range(20, 1), NB'($urandom), $urandom_range(3, 0));
    end
    for (int i = 0; i < NR; i++) chk("fair_grants", grants[i], 3);
    drain();

    arm(2, WB'($urandom));
    do_job(TO + 10, NB'($urandom), 0);
    arm(2, WB'($urandom));
    do_job(TO, NB'($urandom), 0);
    arm(3, WB'($urandom));
    do_job(5, NB'($urandom), 20);
    arm(0, WB'($urandom));
    do_job(3, 17'h0AAAA, 0);
    arm(0, WB'($urandom));
    do_job(1, 17'h15555, 0);

    reset_mid_wait();

    for (int j = 0; j < 30; j++) begin
      arm_random();
      do_job($urandom_range(TO + 10, 1), NB'($urandom), $urandom_range(5, 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
    $fatal(1);
  end
endmodule
